// File: rtl/maroc_sc_receiver.sv
// Slow-control frame receiver: oversamples D_SC/CK_SC/RSTn_SC and rebuilds each frame.
// Optional comparator against expected_in is built when MAROC_SC_COMPARE_EN is defined.
module maroc_sc_receiver #(
  parameter int FRAME_LEN = 829,
  parameter int CNT_W     = 10,
  parameter int TIMEOUT   = 64
) (
  input  logic                 clk_in,
  input  logic                 reset_in,
  input  logic                 D_SC_in,
  input  logic                 CK_SC_in,
  input  logic                 RSTn_SC_in,
`ifdef MAROC_SC_COMPARE_EN
  input  logic [FRAME_LEN-1:0] expected_in,
  output logic                 mismatch_out,
`endif
  output logic [FRAME_LEN-1:0] frame_out,
  output logic                 frame_valid_out,
  output logic [CNT_W-1:0]     bit_cnt_out,
  output logic                 overflow_out,
  output logic                 timeout_out,
  output logic [1:0]           state_out
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RECV = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;
  localparam int TW = $clog2(TIMEOUT + 1);

  logic ck_s1_q, ck_s2_q, ck_prev_q, d_s1_q, d_s2_q, rn_s1_q, rn_s2_q;
  logic [FRAME_LEN-1:0] shreg_q, shreg_d, frame_q, frame_d, cap;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [TW-1:0]        idle_q, idle_d;
  logic [1:0]           st_q, st_d;
  logic                 vld_q, vld_d, ovf_q, ovf_d, to_q, to_d;
  logic                 ck_edge, tmo;

  // Data and clock share the same synchroniser depth so the sampled bit lines up with its edge.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      {ck_s1_q, ck_s2_q, ck_prev_q} <= 3'b000;
      {d_s1_q, d_s2_q}              <= 2'b00;
      {rn_s1_q, rn_s2_q}            <= 2'b00;
    end else begin
      ck_s1_q   <= CK_SC_in;
      ck_s2_q   <= ck_s1_q;
      ck_prev_q <= ck_s2_q;
      d_s1_q    <= D_SC_in;
      d_s2_q    <= d_s1_q;
      rn_s1_q   <= RSTn_SC_in;
      rn_s2_q   <= rn_s1_q;
    end
  end

  assign ck_edge = ck_s2_q & ~ck_prev_q;
  assign cap     = {d_s2_q, shreg_q[FRAME_LEN-1:1]};
  assign tmo     = (idle_q == TW'(TIMEOUT - 1)) && !ck_edge;

`ifdef MAROC_SC_COMPARE_EN
  logic mis_q, mis_d;
`endif

  always_comb begin
    st_d    = st_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    frame_d = frame_q;
    vld_d   = 1'b0;
    ovf_d   = ovf_q;
    to_d    = to_q;
`ifdef MAROC_SC_COMPARE_EN
    mis_d   = mis_q;
`endif
    if (!rn_s2_q) begin
      st_d    = S_IDLE;
      cnt_d   = '0;
      shreg_d = '0;
    end else begin
      case (st_q)
        S_IDLE, S_ERR: begin
          if (ck_edge) begin
            shreg_d = {d_s2_q, {(FRAME_LEN-1){1'b0}}};
            cnt_d   = CNT_W'(1);
            ovf_d   = 1'b0;
            to_d    = 1'b0;
            st_d    = S_RECV;
          end else if (st_q == S_ERR && tmo) begin
            st_d = S_IDLE;
          end
        end
        S_RECV: begin
          if (ck_edge) begin
            shreg_d = cap;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(FRAME_LEN - 1)) begin
              frame_d = cap;
              vld_d   = 1'b1;
              st_d    = S_DONE;
`ifdef MAROC_SC_COMPARE_EN
              mis_d   = (cap != expected_in);
`endif
            end
          end else if (tmo) begin
            to_d = 1'b1;
            st_d = S_ERR;
          end
        end
        default: begin
          if (ck_edge) ovf_d = 1'b1;
          else if (tmo) st_d = S_IDLE;
        end
      endcase
    end
    // Saturating idle counter, restarted by any edge or state change.
    if (ck_edge || st_d != st_q) idle_d = '0;
    else if (idle_q != TW'(TIMEOUT)) idle_d = idle_q + TW'(1);
    else idle_d = idle_q;
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      st_q    <= S_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      frame_q <= '0;
      vld_q   <= 1'b0;
      ovf_q   <= 1'b0;
      to_q    <= 1'b0;
      idle_q  <= '0;
    end else begin
      st_q    <= st_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
      vld_q   <= vld_d;
      ovf_q   <= ovf_d;
      to_q    <= to_d;
      idle_q  <= idle_d;
    end
  end

`ifdef MAROC_SC_COMPARE_EN
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) mis_q <= 1'b0;
    else          mis_q <= mis_d;
  end
  assign mismatch_out = mis_q;
`endif

  assign frame_out       = frame_q;
  assign frame_valid_out = vld_q;
  assign bit_cnt_out     = cnt_q;
  assign overflow_out    = ovf_q;
  assign timeout_out     = to_q;
  assign state_out       = st_q;

endmodule

// File: tb/tb_maroc_sc_receiver.sv
// Directed/randomized bench for maroc_sc_receiver; expected frames are built from the sent bit lists.
module tb_maroc_sc_receiver;
  localparam int FL = 829;
  localparam int CW = 10;

  logic clk = 1'b0, rst = 1'b1, d_sc = 1'b0, ck_sc = 1'b0, rstn_sc = 1'b1;
  logic [FL-1:0] frame_o;
  logic vld_o, ovf_o, to_o;
  logic [CW-1:0] cnt_o;
  logic [1:0] st_o;
`ifdef MAROC_SC_COMPARE_EN
  logic [FL-1:0] exp_in = '0;
  logic mis_o;
`endif

  int checks = 0, errors = 0, vld_seen = 0;

  maroc_sc_receiver #(.FRAME_LEN(FL), .CNT_W(CW), .TIMEOUT(64)) dut (
    .clk_in(clk), .reset_in(rst), .D_SC_in(d_sc), .CK_SC_in(ck_sc), .RSTn_SC_in(rstn_sc),
`ifdef MAROC_SC_COMPARE_EN
    .expected_in(exp_in), .mismatch_out(mis_o),
`endif
    .frame_out(frame_o), .frame_valid_out(vld_o), .bit_cnt_out(cnt_o),
    .overflow_out(ovf_o), .timeout_out(to_o), .state_out(st_o));

  always #5 clk = ~clk;
  always @(negedge clk) if (vld_o) vld_seen++;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [FL-1:0] obs, input logic [FL-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // CK_SC at clk/4: data set up one cycle before the rising edge.
  task automatic send_bit(input logic b);
    d_sc = b;  tick(1);
    ck_sc = 1'b1; tick(2);
    ck_sc = 1'b0; tick(1);
  endtask

  task automatic send_bits(input logic [FL-1:0] f, input int n);
    for (int k = 0; k < n; k++) send_bit(f[k]);
  endtask

  function automatic logic [FL-1:0] rand_frame();
    logic [FL-1:0] f;
    for (int k = 0; k < FL; k++) f[k] = 1'($urandom_range(0, 1));
    return f;
  endfunction

  initial begin
    logic [FL-1:0] f, last_frame, pat;
    int v0;
    tick(3);
    // reset state
    chk("rst_frame", frame_o, '0);
    chk("rst_valid", FL'(vld_o), '0);
    chk("rst_cnt",   FL'(cnt_o), '0);
    chk("rst_ovf",   FL'(ovf_o), '0);
    chk("rst_to",    FL'(to_o), '0);
    chk("rst_state", FL'(st_o), '0);
    rst = 1'b0;
    tick(4);

    // alternating 1,0,1,... frame
    for (int k = 0; k < FL; k++) pat[k] = (k % 2 == 0);
`ifdef MAROC_SC_COMPARE_EN
    exp_in = pat;
`endif
    v0 = vld_seen;
    send_bits(pat, FL); tick(4);
    chk("alt_vcount", FL'(vld_seen - v0), FL'(1));
    chk("alt_frame", frame_o, pat);
    chk("alt_b0",   FL'(frame_o[0]), FL'(1));
    chk("alt_b828", FL'(frame_o[828]), FL'(1));
    chk("alt_cnt",  FL'(cnt_o), FL'(FL));
    chk("alt_state", FL'(st_o), FL'(2));
    chk("alt_ovf", FL'(ovf_o), '0);
    chk("alt_to",  FL'(to_o), '0);
`ifdef MAROC_SC_COMPARE_EN
    chk("cmp_equal", FL'(mis_o), '0);
`endif
    tick(80);
    chk("alt_idle", FL'(st_o), '0);

    // random frame plus 3 extra edges -> overflow
    f = rand_frame();
`ifdef MAROC_SC_COMPARE_EN
    exp_in = f;
    f[764] = ~f[764];
`endif
    v0 = vld_seen;
    send_bits(f, FL);
    for (int k = 0; k < 3; k++) send_bit(1'($urandom_range(0, 1)));
    tick(4);
    chk("ovf_vcount", FL'(vld_seen - v0), FL'(1));
    chk("ovf_frame", frame_o, f);
    chk("ovf_flag",  FL'(ovf_o), FL'(1));
    chk("ovf_state", FL'(st_o), FL'(2));
`ifdef MAROC_SC_COMPARE_EN
    chk("cmp_flip764", FL'(mis_o), FL'(1));
`endif
    last_frame = f;
    tick(80);
    chk("ovf_idle", FL'(st_o), '0);

    // 400 bits then silence -> timeout abort
    v0 = vld_seen;
    send_bits(rand_frame(), 400); tick(80);
    chk("to_state", FL'(st_o), FL'(3));
    chk("to_flag",  FL'(to_o), FL'(1));
    chk("to_cnt",   FL'(cnt_o), FL'(400));
    chk("to_vcount", FL'(vld_seen - v0), '0);
    chk("to_frame", frame_o, last_frame);

    // link reset after 500 bits, then a full 0xA5 frame
    send_bits(rand_frame(), 500);
    rstn_sc = 1'b0; tick(5);
    chk("lrst_cnt",   FL'(cnt_o), '0);
    chk("lrst_state", FL'(st_o), '0);
    send_bits(rand_frame(), 3); tick(2);
    chk("lrst_ignore", FL'(cnt_o), '0);
    chk("lrst_frame", frame_o, last_frame);
    rstn_sc = 1'b1; tick(5);
    for (int k = 0; k < FL; k++) pat[k] = (8'hA5 >> (k % 8)) & 8'h01;
    v0 = vld_seen;
    send_bits(pat, FL); tick(4);
    chk("a5_vcount", FL'(vld_seen - v0), FL'(1));
    chk("a5_frame", frame_o, pat);
    tick(80);

    // random frames back to back after idle
    for (int r = 0; r < 2; r++) begin
      f = rand_frame();
`ifdef MAROC_SC_COMPARE_EN
      exp_in = f;
`endif
      v0 = vld_seen;
      send_bits(f, FL); tick(4);
      chk("rnd_vcount", FL'(vld_seen - v0), FL'(1));
      chk("rnd_frame", frame_o, f);
      tick(80);
    end

    // asynchronous reset at bit 300
    f = rand_frame();
    send_bits(f, 300);
    #2 rst = 1'b1; #1;
    chk("arst_frame", frame_o, '0);
    chk("arst_valid", FL'(vld_o), '0);
    chk("arst_cnt",   FL'(cnt_o), '0);
    chk("arst_ovf",   FL'(ovf_o), '0);
    chk("arst_to",    FL'(to_o), '0);
    chk("arst_state", FL'(st_o), '0);
    tick(1); rst = 1'b0; tick(2);
    v0 = vld_seen;
    for (int k = 300; k < FL; k++) send_bit(f[k]);
    tick(4);
    chk("arst_rest_cnt", FL'(cnt_o), FL'(529));
    chk("arst_rest_state", FL'(st_o), FL'(1));
    chk("arst_vcount", FL'(vld_seen - v0), '0);
    tick(80);
    chk("arst_to_state", FL'(st_o), FL'(3));
    chk("arst_to_flag", FL'(to_o), FL'(1));
    chk("arst_frame_kept", frame_o, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
